// File: rtl/clock_pkg.sv
// Shared definitions for the push-button front end: default timing constants,
// per-key state encoding and a counter sizing helper.
package clock_pkg;

  localparam int          DEF_CLK_HZ     = 50_000_000;
  localparam int          DEF_TICK_HZ    = 1000;
  localparam int          DEF_DEB_TICKS  = 10;
  localparam int          DEF_HOLD_TICKS = 500;
  localparam int          DEF_RPT_TICKS  = 100;
  localparam logic [3:0]  DEF_RPT_MASK   = 4'b0100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEB_DN,
    ST_HELD,
    ST_REPEAT,
    ST_DEB_UP
  } key_state_e;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/key_fsm.sv
// One push-button channel: 2-FF synchronizer, tick-based debounce, hold
// detection and optional auto-repeat, all outputs registered.
module key_fsm
  import clock_pkg::*;
#(
  parameter int DEB_TICKS  = DEF_DEB_TICKS,
  parameter int HOLD_TICKS = DEF_HOLD_TICKS,
  parameter int RPT_TICKS  = DEF_RPT_TICKS,
  parameter bit RPT_EN     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic sw_n,
  output logic o_press,
  output logic o_level,
  output logic o_long
);

  localparam int DW = cnt_width(DEB_TICKS);
  localparam int HW = cnt_width(HOLD_TICKS);
  localparam int RW = cnt_width(RPT_TICKS);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_TICKS - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_TICKS);
  localparam logic [RW-1:0] RPT_LAST  = RW'(RPT_TICKS - 1);

  logic          sync1_q, sync2_q;
  logic          key;
  key_state_e    state_q, state_d;
  logic [DW-1:0] deb_q, deb_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [RW-1:0] rpt_q, rpt_d;
  logic          press_q, press_d;
  logic          level_q, level_d;
  logic          long_q, long_d;

  assign key = ~sync2_q;

  always_comb begin
    state_d = state_q;
    deb_d   = deb_q;
    hold_d  = hold_q;
    rpt_d   = rpt_q;
    press_d = 1'b0;
    long_d  = 1'b0;
    level_d = level_q;

    unique case (state_q)
      ST_IDLE: begin
        if (key) begin
          state_d = ST_DEB_DN;
          deb_d   = '0;
        end
      end

      ST_DEB_DN: begin
        if (!key) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (deb_q == DEB_LAST) begin
            state_d = ST_HELD;
            level_d = 1'b1;
            press_d = 1'b1;
            hold_d  = '0;
          end else begin
            deb_d = deb_q + 1'b1;
          end
        end
      end

      // The hold counter saturates at HOLD_TICKS, so o_long fires only once.
      ST_HELD: begin
        if (!key) begin
          state_d = ST_DEB_UP;
          deb_d   = '0;
        end else if (tick && (hold_q != HOLD_MAX)) begin
          hold_d = hold_q + 1'b1;
          if (hold_q == HOLD_LAST) begin
            long_d = 1'b1;
            if (RPT_EN) begin
              state_d = ST_REPEAT;
              rpt_d   = RPT_LAST;
            end
          end
        end
      end

      ST_REPEAT: begin
        if (!key) begin
          state_d = ST_DEB_UP;
          deb_d   = '0;
        end else if (tick) begin
          if (rpt_q == RPT_LAST) begin
            press_d = 1'b1;
            rpt_d   = '0;
          end else begin
            rpt_d = rpt_q + 1'b1;
          end
        end
      end

      // A saturated hold counter on a repeat-enabled key means we came from REPEAT.
      ST_DEB_UP: begin
        if (key) begin
          state_d = (RPT_EN && (hold_q == HOLD_MAX)) ? ST_REPEAT : ST_HELD;
        end else if (tick) begin
          if (deb_q == DEB_LAST) begin
            state_d = ST_IDLE;
            level_d = 1'b0;
          end else begin
            deb_d = deb_q + 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= ST_IDLE;
      deb_q   <= '0;
      hold_q  <= '0;
      rpt_q   <= '0;
      press_q <= 1'b0;
      level_q <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      sync1_q <= sw_n;
      sync2_q <= sync1_q;
      state_q <= state_d;
      deb_q   <= deb_d;
      hold_q  <= hold_d;
      rpt_q   <= rpt_d;
      press_q <= press_d;
      level_q <= level_d;
      long_q  <= long_d;
    end
  end

  assign o_press = press_q;
  assign o_level = level_q;
  assign o_long  = long_q;

endmodule

// File: rtl/key_repeat.sv
// Four-button front end: one shared tick prescaler feeding four independent
// debounce / hold / auto-repeat channels.
module key_repeat
  import clock_pkg::*;
#(
  parameter int         CLK_HZ     = DEF_CLK_HZ,
  parameter int         TICK_HZ    = DEF_TICK_HZ,
  parameter int         DEB_TICKS  = DEF_DEB_TICKS,
  parameter int         HOLD_TICKS = DEF_HOLD_TICKS,
  parameter int         RPT_TICKS  = DEF_RPT_TICKS,
  parameter logic [3:0] RPT_MASK   = DEF_RPT_MASK
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] i_sw,
  output logic [3:0] o_press,
  output logic [3:0] o_level,
  output logic [3:0] o_long
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = cnt_width(DIV - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic          tick_q, tick_d;

  always_comb begin
    pre_d  = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
    tick_d = (pre_q == PRE_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= tick_d;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_key
    key_fsm #(
      .DEB_TICKS (DEB_TICKS),
      .HOLD_TICKS(HOLD_TICKS),
      .RPT_TICKS (RPT_TICKS),
      .RPT_EN    (RPT_MASK[g])
    ) u_key (
      .clk    (clk),
      .rst    (rst),
      .tick   (tick_q),
      .sw_n   (i_sw[g]),
      .o_press(o_press[g]),
      .o_level(o_level[g]),
      .o_long (o_long[g])
    );
  end

endmodule

// File: doc/key_repeat.md
KEY_REPEAT -- requirements
Module: key_repeat

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, system clock frequency.
REQ-002 SHALL have parameter TICK_HZ, default 1000, internal time-base rate.
REQ-003 SHALL have parameter DEB_TICKS, default 10, stable-tick count required to accept a level change.
REQ-004 SHALL have parameter HOLD_TICKS, default 500, held-tick count before auto-repeat starts.
REQ-005 SHALL have parameter RPT_TICKS, default 100, tick period between repeat pulses.
REQ-006 SHALL have parameter RPT_MASK, default 4'b0100, keys allowed to auto-repeat (sw2 = increment key).
REQ-007 SHALL have port clk, input, 1, single system clock; all logic on rising edge.
REQ-008 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-009 SHALL have port i_sw, input, 4, raw asynchronous push-buttons, active-low (0 = pressed).
REQ-010 SHALL have port o_press, output, 4, one-clk pulse per accepted press or repeat, per key.
REQ-011 SHALL have port o_level, output, 4, debounced key state, active-high (1 = pressed).
REQ-012 SHALL have port o_long, output, 4, one-clk pulse when a key reaches HOLD_TICKS.

Function
REQ-013 SHALL pass each i_sw bit through a 2-FF synchronizer and invert it before any other use.
REQ-014 SHALL generate a one-clk tick every CLK_HZ/TICK_HZ clocks from a counter that wraps from CLK_HZ/TICK_HZ-1 to 0.
REQ-015 SHALL run one independent FSM per key with states IDLE, DEB_DN, HELD, REPEAT, DEB_UP.
REQ-016 IDLE: synchronized key = 1 -> DEB_DN with tick counter cleared.
REQ-017 DEB_DN: key = 0 on any clk -> IDLE; DEB_TICKS ticks counted with key = 1 -> HELD, o_level = 1, o_press pulse in the same clk as the transition.
REQ-018 HELD: key = 0 -> DEB_UP; HOLD_TICKS ticks counted -> o_long pulse, then REPEAT if the key's RPT_MASK bit = 1, otherwise stay HELD with no further o_long.
REQ-019 REPEAT: o_press pulse on the first tick and on every RPT_TICKS-th tick thereafter; key = 0 -> DEB_UP.
REQ-020 DEB_UP: key = 1 on any clk -> back to prior held state (HELD or REPEAT) with counters unchanged; DEB_TICKS ticks counted with key = 0 -> IDLE, o_level = 0.
REQ-021 Tick counters SHALL saturate at their limit, never wrap, and be sized from the parameters.
REQ-022 o_press and o_long SHALL each be high for exactly one clk per event and never two consecutive clks for the same key.
REQ-023 Simultaneous presses on several keys SHALL be handled independently; identical timing SHALL give pulses in the same clk.
REQ-024 Input glitches shorter than DEB_TICKS ticks SHALL produce no change on any output.
REQ-025 All outputs SHALL be registered; a press is reported no earlier than DEB_TICKS ticks plus 3 clks after the i_sw edge.

Reset
REQ-026 rst = 1 at a clk edge SHALL clear synchronizers (to released), tick prescaler, all FSMs to IDLE, and all counters.
REQ-027 During and after reset, o_press = 0, o_long = 0, o_level = 0; a key held through reset SHALL be re-debounced as a new press.
REQ-028 Reset asserted mid-debounce or mid-repeat SHALL abort the event with no pulse emitted.

Structure
REQ-029 State encoding and default timing constants SHALL live in shared package clock_pkg.
REQ-030 One sub-module key_fsm (synchronizer, counters, FSM for one key) SHALL be instantiated four times.
REQ-031 The tick prescaler SHALL live in key_repeat and be shared by all key_fsm instances.
REQ-032 Outputs SHALL be glitch-free registers suitable to drive the clock controller's mode, position, set and alarm inputs.

Verification (sim params: CLK_HZ=1000, TICK_HZ=100 (tick every 10 clks), DEB_TICKS=3, HOLD_TICKS=10, RPT_TICKS=4)
REQ-033 i_sw[0] low for 200 clks -> one o_press[0] pulse about 33 clks after the edge; o_level[0] = 1 until about 30 clks after release; o_long[0] at 10 ticks, no repeats.
REQ-034 i_sw[0] low for 15 clks (1 tick) -> no output activity.
REQ-035 i_sw[2] held for 300 clks -> initial press, o_long[2] at 10 ticks, then o_press[2] every 40 clks until release.
REQ-036 i_sw[2] held in REPEAT, one-tick bounce high -> repeat cadence continues and o_level stays 1.
REQ-037 i_sw[1] and i_sw[3] pressed in the same clk -> o_press[1] and o_press[3] asserted in the same clk.
REQ-038 rst pulsed while i_sw[2] held in REPEAT -> outputs 0 next clk; a new press is reported after DEB_TICKS ticks.
